// File: rtl/main_fsm.sv
// main_fsm: multicycle RISC-V control FSM stepping fetch/decode/execute/memory/writeback one state per cycle
// Ports: clk; reset (synchronous, active-high); op, Zero, MemReady in;
//   ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite datapath controls out;
//   InstRet retired-instruction count; Illegal sticky illegal-opcode flag.
// Params: USE_MEM_READY makes FETCH/MEMREAD/MEMWRITE wait for MemReady; ICOUNT_W sets InstRet width.
// Define ILLEGAL_TRAP_EN to park unlisted opcodes in a terminal ILLEGAL state; otherwise they retire as NOPs.
module main_fsm #(
  parameter bit USE_MEM_READY = 1'b1,
  parameter int ICOUNT_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          op,
  input  logic                Zero,
  input  logic                MemReady,
  output logic [1:0]          ALUOp,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ResultSrc,
  output logic                AdrSrc,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic [ICOUNT_W-1:0] InstRet,
  output logic                Illegal
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, ILLEGAL
  } state_t;
  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] res_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic       mem_write;
  } ctl_t;
  localparam ctl_t CTL_FETCH = '{alu_op: 2'b00, src_a: 2'b00, src_b: 2'b10, res_src: 2'b10,
                                 adr_src: 1'b0, ir_write: 1'b1, pc_update: 1'b1,
                                 branch: 1'b0, reg_write: 1'b0, mem_write: 1'b0};
  state_t state_q, state_d;
  ctl_t ctl_q, ctl_d, ctl;
  logic [ICOUNT_W-1:0] inst_ret_q, inst_ret_d;
  logic ready, retire;
  assign ready = USE_MEM_READY ? MemReady : 1'b1;
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    state_d = ready ? DECODE : FETCH;
      DECODE:
        case (op)
          7'b0000011, 7'b0100011: state_d = MEMADR;
          7'b0110011:             state_d = EXECUTER;
          7'b0010011:             state_d = EXECUTEI;
          7'b1101111:             state_d = JAL;
          7'b1100011:             state_d = BEQ;
`ifdef ILLEGAL_TRAP_EN
          default:                state_d = ILLEGAL;
`else
          default:                state_d = FETCH;
`endif
        endcase
      MEMADR:   state_d = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  state_d = ready ? MEMWB : MEMREAD;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = ready ? FETCH : MEMWRITE;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      JAL:      state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BEQ:      state_d = FETCH;
      ILLEGAL:  state_d = ILLEGAL;
      default:  state_d = FETCH;
    endcase
  end
  always_comb begin
    ctl_d = '0;
    case (state_d)
      FETCH:    ctl_d = CTL_FETCH;
      DECODE:   begin ctl_d.src_a = 2'b01; ctl_d.src_b = 2'b01; end
      MEMADR:   begin ctl_d.src_a = 2'b10; ctl_d.src_b = 2'b01; end
      MEMREAD:  ctl_d.adr_src = 1'b1;
      MEMWB:    begin ctl_d.res_src = 2'b01; ctl_d.reg_write = 1'b1; end
      MEMWRITE: begin ctl_d.adr_src = 1'b1; ctl_d.mem_write = 1'b1; end
      EXECUTER: begin ctl_d.src_a = 2'b10; ctl_d.alu_op = 2'b10; end
      EXECUTEI: begin ctl_d.src_a = 2'b10; ctl_d.src_b = 2'b01; ctl_d.alu_op = 2'b10; end
      ALUWB:    ctl_d.reg_write = 1'b1;
      BEQ:      begin ctl_d.src_a = 2'b10; ctl_d.alu_op = 2'b01; ctl_d.branch = 1'b1; end
      JAL:      begin ctl_d.src_a = 2'b01; ctl_d.src_b = 2'b10; ctl_d.pc_update = 1'b1; end
      default:  ctl_d = '0;
    endcase
  end
  assign retire = (state_q != FETCH) && (state_d == FETCH);
  assign inst_ret_d = inst_ret_q + ICOUNT_W'(retire);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      ctl_q <= CTL_FETCH;
      inst_ret_q <= '0;
    end else begin
      state_q <= state_d;
      ctl_q <= ctl_d;
      inst_ret_q <= inst_ret_d;
    end
  end
`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign illegal_d = illegal_q | (state_d == ILLEGAL);
  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else illegal_q <= illegal_d;
  end
  assign Illegal = illegal_q;
`else
  assign Illegal = 1'b0;
`endif
  assign ctl = reset ? '0 : ctl_q;
  assign ALUOp = ctl.alu_op;
  assign ALUSrcA = ctl.src_a;
  assign ALUSrcB = ctl.src_b;
  assign ResultSrc = ctl.res_src;
  assign AdrSrc = ctl.adr_src;
  assign IRWrite = ctl.ir_write & ready;
  assign PCWrite = (ctl.pc_update & ~(ctl.ir_write & ~ready)) | (ctl.branch & Zero);
  assign RegWrite = ctl.reg_write;
  assign MemWrite = ctl.mem_write;
  assign InstRet = inst_ret_q;
endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: directed self-checking bench for main_fsm
module tb_main_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] op = 7'b0;
  logic Zero = 1'b0;
  logic MemReady = 1'b1;
  logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
  logic AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Illegal;
  logic [31:0] InstRet;
  logic [12:0] sig;
  int checks = 0;
  int passed = 0;
  logic [31:0] ret = 0;
  localparam logic [12:0] S_FETCH = 13'b00_00_10_10_0_1_1_0_0;
  localparam logic [12:0] S_STALL = 13'b00_00_10_10_0_0_0_0_0;
  localparam logic [12:0] S_DECODE = 13'b00_01_01_00_0_0_0_0_0;
  localparam logic [12:0] S_MEMADR = 13'b00_10_01_00_0_0_0_0_0;
  localparam logic [12:0] S_MEMREAD = 13'b00_00_00_00_1_0_0_0_0;
  localparam logic [12:0] S_MEMWB = 13'b00_00_00_01_0_0_0_1_0;
  localparam logic [12:0] S_MEMWR = 13'b00_00_00_00_1_0_0_0_1;
  localparam logic [12:0] S_EXR = 13'b10_10_00_00_0_0_0_0_0;
  localparam logic [12:0] S_EXI = 13'b10_10_01_00_0_0_0_0_0;
  localparam logic [12:0] S_ALUWB = 13'b00_00_00_00_0_0_0_1_0;
  localparam logic [12:0] S_BEQ0 = 13'b01_10_00_00_0_0_0_0_0;
  localparam logic [12:0] S_BEQ1 = 13'b01_10_00_00_0_0_1_0_0;
  localparam logic [12:0] S_JAL = 13'b00_01_10_00_0_0_1_0_0;
  main_fsm dut (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero), .MemReady(MemReady),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .InstRet(InstRet), .Illegal(Illegal)
  );
  assign sig = {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite};
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic test_reset();
    tick();
    tick();
    checks++; if (sig !== 13'b0) $display("FAIL reset_ctl: got %b expected %b", sig, 13'b0); else passed++;
    checks++; if (InstRet !== 32'd0) $display("FAIL reset_instret: got %0d expected 0", InstRet); else passed++;
    checks++; if (Illegal !== 1'b0) $display("FAIL reset_illegal: got %b expected 0", Illegal); else passed++;
    reset = 1'b0;
    #1;
    checks++; if (sig !== S_FETCH) $display("FAIL reset_fetch: got %b expected %b", sig, S_FETCH); else passed++;
  endtask
  task automatic test_lw();
    logic [12:0] e [5];
    e = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB};
    op = 7'b0000011;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (sig !== e[i]) $display("FAIL lw_step%0d: got %b expected %b", i, sig, e[i]); else passed++;
      tick();
    end
    ret++;
    checks++; if (sig !== S_FETCH) $display("FAIL lw_done: got %b expected %b", sig, S_FETCH); else passed++;
    checks++; if (InstRet !== ret) $display("FAIL lw_instret: got %0d expected %0d", InstRet, ret); else passed++;
  endtask
  task automatic test_rtype();
    logic [12:0] e [4];
    e = '{S_FETCH, S_DECODE, S_EXR, S_ALUWB};
    op = 7'b0110011;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (sig !== e[i]) $display("FAIL rtype_step%0d: got %b expected %b", i, sig, e[i]); else passed++;
      tick();
    end
    ret++;
    checks++; if (sig !== S_FETCH) $display("FAIL rtype_done: got %b expected %b", sig, S_FETCH); else passed++;
    checks++; if (InstRet !== ret) $display("FAIL rtype_instret: got %0d expected %0d", InstRet, ret); else passed++;
  endtask
  task automatic test_beq();
    logic [12:0] e [3];
    for (int z = 1; z >= 0; z--) begin
      e = '{S_FETCH, S_DECODE, (z == 1) ? S_BEQ1 : S_BEQ0};
      op = 7'b1100011;
      Zero = z[0];
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++; if (sig !== e[i]) $display("FAIL beq_z%0d_step%0d: got %b expected %b", z, i, sig, e[i]); else passed++;
        tick();
      end
      Zero = 1'b0;
      ret++;
      #1;
      checks++; if (sig !== S_FETCH) $display("FAIL beq_z%0d_done: got %b expected %b", z, sig, S_FETCH); else passed++;
      checks++; if (InstRet !== ret) $display("FAIL beq_z%0d_instret: got %0d expected %0d", z, InstRet, ret); else passed++;
    end
  endtask
  task automatic test_stall();
    op = 7'b0110011;
    MemReady = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (sig !== S_STALL) $display("FAIL stall_fetch%0d: got %b expected %b", i, sig, S_STALL); else passed++;
      tick();
    end
    checks++; if (InstRet !== ret) $display("FAIL stall_instret: got %0d expected %0d", InstRet, ret); else passed++;
    MemReady = 1'b1;
    #1;
    checks++; if (sig !== S_FETCH) $display("FAIL stall_release: got %b expected %b", sig, S_FETCH); else passed++;
    tick();
    checks++; if (sig !== S_DECODE) $display("FAIL stall_decode: got %b expected %b", sig, S_DECODE); else passed++;
    tick();
    tick();
    tick();
    ret++;
    checks++; if (InstRet !== ret) $display("FAIL stall_retire: got %0d expected %0d", InstRet, ret); else passed++;
  endtask
  task automatic test_back_to_back();
    logic [12:0] e [3];
    logic [6:0] ops [2];
    logic [12:0] mid [2];
    e = '{S_FETCH, S_DECODE, S_MEMADR};
    op = 7'b0100011;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (sig !== e[i]) $display("FAIL sw_step%0d: got %b expected %b", i, sig, e[i]); else passed++;
      tick();
    end
    MemReady = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (sig !== S_MEMWR) $display("FAIL sw_hold%0d: got %b expected %b", i, sig, S_MEMWR); else passed++;
      tick();
    end
    MemReady = 1'b1;
    #1;
    checks++; if (sig !== S_MEMWR) $display("FAIL sw_ready: got %b expected %b", sig, S_MEMWR); else passed++;
    tick();
    ret++;
    checks++; if (InstRet !== ret) $display("FAIL sw_instret: got %0d expected %0d", InstRet, ret); else passed++;
    ops = '{7'b0010011, 7'b1101111};
    mid = '{S_EXI, S_JAL};
    for (int k = 0; k < 2; k++) begin
      op = ops[k];
      #1;
      checks++; if (sig !== S_FETCH) $display("FAIL b2b%0d_fetch: got %b expected %b", k, sig, S_FETCH); else passed++;
      tick();
      checks++; if (sig !== S_DECODE) $display("FAIL b2b%0d_decode: got %b expected %b", k, sig, S_DECODE); else passed++;
      tick();
      checks++; if (sig !== mid[k]) $display("FAIL b2b%0d_exec: got %b expected %b", k, sig, mid[k]); else passed++;
      tick();
      checks++; if (sig !== S_ALUWB) $display("FAIL b2b%0d_wb: got %b expected %b", k, sig, S_ALUWB); else passed++;
      tick();
      ret++;
      checks++; if (InstRet !== ret) $display("FAIL b2b%0d_instret: got %0d expected %0d", k, InstRet, ret); else passed++;
    end
  endtask
  task automatic test_reset_mid();
    op = 7'b0100011;
    tick();
    tick();
    tick();
    checks++; if (MemWrite !== 1'b1) $display("FAIL rmid_memwrite: got %b expected 1", MemWrite); else passed++;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (sig !== 13'b0) $display("FAIL rmid_ctl%0d: got %b expected %b", i, sig, 13'b0); else passed++;
      tick();
    end
    reset = 1'b0;
    ret = 0;
    #1;
    checks++; if (sig !== S_FETCH) $display("FAIL rmid_fetch: got %b expected %b", sig, S_FETCH); else passed++;
    checks++; if (InstRet !== ret) $display("FAIL rmid_instret: got %0d expected %0d", InstRet, ret); else passed++;
  endtask
  task automatic test_illegal();
    op = 7'b1111111;
    #1;
    tick();
    tick();
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      checks++; if (sig !== 13'b0) $display("FAIL ill_ctl%0d: got %b expected %b", i, sig, 13'b0); else passed++;
      checks++; if (Illegal !== 1'b1) $display("FAIL ill_flag%0d: got %b expected 1", i, Illegal); else passed++;
      checks++; if (InstRet !== ret) $display("FAIL ill_instret%0d: got %0d expected %0d", i, InstRet, ret); else passed++;
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ret = 0;
    #1;
    checks++; if (Illegal !== 1'b0) $display("FAIL ill_clear: got %b expected 0", Illegal); else passed++;
    checks++; if (sig !== S_FETCH) $display("FAIL ill_fetch: got %b expected %b", sig, S_FETCH); else passed++;
`else
    ret++;
    checks++; if (sig !== S_FETCH) $display("FAIL nop_fetch: got %b expected %b", sig, S_FETCH); else passed++;
    checks++; if (InstRet !== ret) $display("FAIL nop_instret: got %0d expected %0d", InstRet, ret); else passed++;
    checks++; if (Illegal !== 1'b0) $display("FAIL nop_illegal: got %b expected 0", Illegal); else passed++;
`endif
  endtask
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
